change_dispenser: RTL
=====================

Name: change_dispenser

Overview:
- Pays out change after a vend, coin by coin. Counterpart of the payment side: the display/payment logic counts incoming dollar/quarter/dime/nickel pulses, and this block drives outgoing coin-release lines to the hopper mechanism.
- Accepts a change amount in cents, dispenses greedily (largest denomination first), and uses a 4-phase handshake per coin with an ack timeout.

Parameters:
- AMT_W, 12, width of amount and remaining (cents).
- TIMEOUT, 1023, max cycles waiting on each coin_ack edge before error.
- CNT_W, 8, width of coin_count.
- INV_W, 8, inventory counter width (CHANGE_INV_EN only).
- INV_INIT, 20, coins per denomination after reset/restock (CHANGE_INV_EN only).

Ports:
- clk_fast  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request payout; sampled in IDLE only.
- change_amt  in  AMT_W  cents to return; sampled with start.
- coin_ack  in  1  hopper acknowledge; high = coin released, low = ready.
- dollar_out  out  1  release one dollar coin (level, held until ack).
- quarter_out  out  1  release one quarter.
- dime_out  out  1  release one dime.
- nickel_out  out  1  release one nickel.
- busy  out  1  high from accepted start until done or error.
- done  out  1  one-cycle pulse; payout complete.
- error  out  1  sticky; set on bad amount, timeout or no change; cleared by next accepted start.
- remaining  out  AMT_W  cents still owed.
- coin_count  out  CNT_W  coins released this payout; saturates at all-ones.

Behaviour:
- Reset (asynchronous, any state): state IDLE; all coin lines 0; busy, done, error 0; remaining 0; coin_count 0; timer 0.
- Coin outputs are registered and at most one is high at a time.
- IDLE:
  - start=1 and change_amt%5!=0: error=1 next cycle, remaining=change_amt, stay IDLE, busy stays 0.
  - start=1 otherwise: load remaining=change_amt, clear coin_count and error, busy=1, go SELECT.
  - start while busy is ignored.
- SELECT:
  - remaining==0: go DONE.
  - Otherwise pick the largest of 100/25/10/5 that is ≤ remaining and go REQ. The chosen line rises on entry to REQ, so the first coin line is high 2 cycles after the start edge.
- REQ (coin line high, timer counting):
  - coin_ack=1 sampled: next edge drops the line, remaining -= denomination, coin_count += 1, timer cleared, go GAP.
  - timer reaches TIMEOUT: drop the line, error=1, busy=0, go IDLE; remaining is not decremented.
- GAP (all lines low):
  - coin_ack=0 sampled: timer cleared, go SELECT.
  - timer reaches TIMEOUT: error=1, busy=0, go IDLE.
- DONE: done=1 for exactly one cycle, busy=0, go IDLE.
- Ack already high on entry to REQ: counts as ack on that first REQ cycle.
- Arithmetic: remaining is never negative, because selection guarantees denomination ≤ remaining. change_amt=0 gives done 2 cycles after start with no coin released.
- Reset mid-handshake: coin line drops immediately and the payout is abandoned; no partial credit is retained.

Optional Feature:
- Macro CHANGE_INV_EN.
- Defined:
  - Adds input restock (1 bit) and output inv_low (4 bits, one per denomination, high when that count is 0).
  - Four INV_W inventory counters set to INV_INIT at reset and on restock. restock is honoured in IDLE only.
  - Each counter decrements on ack of its coin.
  - SELECT skips denominations with zero stock (greedy, no backtracking).
  - If remaining>0 and no denomination is both ≤ remaining and stocked: error=1, busy=0, go IDLE, remaining holds the shortfall.
- Undefined: inventory is treated as unlimited; no restock or inv_low ports.

Test Plan:
- change_amt=185, bench acks each coin after 3 cycles and releases after 2 -> sequence dollar, quarter, quarter, quarter, dime; coin_count=5, remaining=0, done pulse once, error=0.
- change_amt=30 -> quarter then nickel; busy high throughout; done pulse; busy low the same cycle done is high.
- change_amt=0 -> no coin line ever high; done 2 cycles after start. change_amt=37 -> error=1, busy stays 0, no coins released.
- change_amt=100, coin_ack held low -> dollar_out high for TIMEOUT cycles then low; error=1; remaining=100; next start of 5 clears error and releases a nickel.
- rst_n pulled low while quarter_out is high mid-payout -> all outputs 0 asynchronously; after release, state IDLE, and start with 10 gives one dime.
- CHANGE_INV_EN, INV_INIT=1, change_amt=60 -> quarter, dime, dime? No: dime stock is 1, so quarter, dime, nickel, then shortfall 20 -> error=1, remaining=20, inv_low=quarter|dime|nickel. restock, then change_amt=20 -> dime, nickel, nickel? No: nickel stock is 1, so dime, nickel, then error with remaining=5.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin payout with a per-coin 4-phase hopper handshake.
// Optional inventory tracking is compiled in with `define CHANGE_INV_EN.
module change_dispenser #(
  parameter int AMT_W   = 12,
  parameter int TIMEOUT = 1023,
`ifdef CHANGE_INV_EN
  parameter int INV_W    = 8,
  parameter int INV_INIT = 20,
`endif
  parameter int CNT_W   = 8
) (
  input  logic             clk_fast,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AMT_W-1:0] change_amt,
  input  logic             coin_ack,
`ifdef CHANGE_INV_EN
  input  logic             restock,
  output logic [3:0]       inv_low,
`endif
  output logic             dollar_out,
  output logic             quarter_out,
  output logic             dime_out,
  output logic             nickel_out,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [AMT_W-1:0] remaining,
  output logic [CNT_W-1:0] coin_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_REQ,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       coin_q, coin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    timer_q, timer_d;

  logic [3:0]       stock;
  logic [3:0]       can;
  logic [3:0]       pick;
  logic [AMT_W-1:0] dval;
  logic             bad_amt;
  logic             tmo;

`ifdef CHANGE_INV_EN
  logic [INV_W-1:0] inv_q [4];
  logic [INV_W-1:0] inv_d [4];

  // a denomination is usable only while its hopper still has coins
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      stock[i] = (inv_q[i] != '0);
    end
  end

  assign inv_low = ~stock;
`else
  assign stock = 4'hF;
`endif

  assign bad_amt = (change_amt % AMT_W'(5)) != '0;
  assign tmo     = (timer_q == TLIM);

  assign can[3] = stock[3] && (rem_q >= AMT_W'(100));
  assign can[2] = stock[2] && (rem_q >= AMT_W'(25));
  assign can[1] = stock[1] && (rem_q >= AMT_W'(10));
  assign can[0] = stock[0] && (rem_q >= AMT_W'(5));

  // greedy choice: largest usable coin not exceeding what is owed
  always_comb begin
    pick = 4'b0000;
    priority case (1'b1)
      can[3]:  pick = 4'b1000;
      can[2]:  pick = 4'b0100;
      can[1]:  pick = 4'b0010;
      can[0]:  pick = 4'b0001;
      default: pick = 4'b0000;
    endcase
  end

  // value of the coin currently being released
  always_comb begin
    dval = '0;
    unique case (1'b1)
      coin_q[3]: dval = AMT_W'(100);
      coin_q[2]: dval = AMT_W'(25);
      coin_q[1]: dval = AMT_W'(10);
      coin_q[0]: dval = AMT_W'(5);
      default:   dval = '0;
    endcase
  end

  // next-state and next-output logic for the payout sequencer
  always_comb begin
    state_d = state_q;
    coin_d  = coin_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
`ifdef CHANGE_INV_EN
    inv_d   = inv_q;
`endif
    unique case (state_q)
      S_IDLE: begin
`ifdef CHANGE_INV_EN
        if (restock) begin
          for (int i = 0; i < 4; i++) begin
            inv_d[i] = INV_W'(INV_INIT);
          end
        end
`endif
        if (start) begin
          rem_d = change_amt;
          if (bad_amt) begin
            error_d = 1'b1;
          end else begin
            cnt_d   = '0;
            error_d = 1'b0;
            busy_d  = 1'b1;
            timer_d = '0;
            state_d = S_SELECT;
          end
        end
      end
      S_SELECT: begin
        timer_d = '0;
        if (rem_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else if (pick != 4'b0000) begin
          coin_d  = pick;
          state_d = S_REQ;
        end else begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (coin_ack) begin
          coin_d  = 4'b0000;
          rem_d   = rem_q - dval;
          timer_d = '0;
          state_d = S_GAP;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`ifdef CHANGE_INV_EN
          for (int i = 0; i < 4; i++) begin
            if (coin_q[i]) begin
              inv_d[i] = inv_q[i] - INV_W'(1);
            end
          end
`endif
        end else if (tmo) begin
          coin_d  = 4'b0000;
          error_d = 1'b1;
          busy_d  = 1'b0;
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_GAP: begin
        if (!coin_ack) begin
          timer_d = '0;
          state_d = S_SELECT;
        end else if (tmo) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        coin_d  = 4'b0000;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // state and registered outputs; reset abandons any payout in flight
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      coin_q  <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      rem_q   <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      coin_q  <= coin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
    end
  end

`ifdef CHANGE_INV_EN
  // per-denomination coin stock, refilled by reset or restock
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        inv_q[i] <= INV_W'(INV_INIT);
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        inv_q[i] <= inv_d[i];
      end
    end
  end
`endif

  assign dollar_out  = coin_q[3];
  assign quarter_out = coin_q[2];
  assign dime_out    = coin_q[1];
  assign nickel_out  = coin_q[0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign remaining   = rem_q;
  assign coin_count  = cnt_q;

endmodule
